// File: rtl/stage_mem_ctrl.sv
// MEM pipeline stage with a bus-handshake FSM for byte/half/word loads and stores.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module stage_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  we_i,
  input  logic [DATA_W-1:0]     reg_wdata_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [3:0]            mem_op_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic                  mem_busy_i,
  input  logic                  mem_done_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic                  we_o,
  output logic [DATA_W-1:0]     reg_wdata_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_sel,
  output logic [DATA_W-1:0]     mem_data_o,
  output logic                  stallreq,
  output logic                  misalign_o,
  output logic                  err_o
);

  // state  | meaning
  // IDLE   | pass-through; issue aligned request when bus is free
  // ACCESS | request held on bus until done strobe
  // RESP   | write back load result, release pipeline
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  if (DATA_W != 32) begin : g_bad_width
    $error("stage_mem_ctrl: DATA_W must be 32");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("stage_mem_ctrl: TIMEOUT_CYC must be at least 1");
  end

  state_t state, state_nx;

  logic is_load, is_store, sz_b, sz_h, sz_w, misalign, mem_req;
  logic [3:0]        sel_nx;
  logic [DATA_W-1:0] sdata_nx;
  logic [ADDR_W-1:0] addr_al;

  logic              req_re, req_we;
  logic [3:0]        req_sel;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] cap_data;
  logic [3:0]        cap_op;
  logic [1:0]        cap_lo;
  logic              cap_load;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [DATA_W-1:0] ld_val;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             timed_out;
  logic             to_hit;

  assign to_hit = (state == ACCESS) && !mem_done_i && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    is_load  = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd5);
    is_store = (mem_op_i >= 4'd6) && (mem_op_i <= 4'd8);
    sz_b     = (mem_op_i == 4'd1) || (mem_op_i == 4'd4) || (mem_op_i == 4'd6);
    sz_h     = (mem_op_i == 4'd2) || (mem_op_i == 4'd5) || (mem_op_i == 4'd7);
    sz_w     = (mem_op_i == 4'd3) || (mem_op_i == 4'd8);
    misalign = (sz_h && mem_addr_i[0]) || (sz_w && (mem_addr_i[1:0] != 2'b00));
    mem_req  = (is_load || is_store) && !misalign;
    addr_al  = {mem_addr_i[ADDR_W-1:2], 2'b00};
    if (sz_b) begin
      sel_nx   = 4'b0001 << mem_addr_i[1:0];
      sdata_nx = {4{rt_data_i[7:0]}};
    end else if (sz_h) begin
      sel_nx   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      sdata_nx = {2{rt_data_i[15:0]}};
    end else begin
      sel_nx   = 4'b1111;
      sdata_nx = rt_data_i;
    end
  end

  // Lane extraction works only from captured state, so RESP does not depend on bus inputs.
  always_comb begin
    cap_load = (cap_op >= 4'd1) && (cap_op <= 4'd5);
    case (cap_lo)
      2'd0:    ld_b = cap_data[7:0];
      2'd1:    ld_b = cap_data[15:8];
      2'd2:    ld_b = cap_data[23:16];
      default: ld_b = cap_data[31:24];
    endcase
    ld_h = cap_lo[1] ? cap_data[31:16] : cap_data[15:0];
    case (cap_op)
      4'd1:    ld_val = {{24{ld_b[7]}}, ld_b};
      4'd2:    ld_val = {{16{ld_h[15]}}, ld_h};
      4'd4:    ld_val = {24'd0, ld_b};
      4'd5:    ld_val = {16'd0, ld_h};
      default: ld_val = cap_data;
    endcase
  end

  always_comb begin
    state_nx    = state;
    reg_waddr_o = reg_waddr_i;
    we_o        = we_i;
    reg_wdata_o = reg_wdata_i;
    mem_addr_o  = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 4'b0000;
    mem_data_o  = '0;
    stallreq    = 1'b0;
    misalign_o  = 1'b0;
    err_o       = 1'b0;
    unique case (state)
      IDLE: begin
        if (misalign) begin
          misalign_o = 1'b1;
          we_o       = 1'b0;
        end else if (mem_req) begin
          stallreq = 1'b1;
          we_o     = 1'b0;
          if (!mem_busy_i) begin
            mem_re     = is_load;
            mem_we     = is_store;
            mem_sel    = sel_nx;
            mem_addr_o = addr_al;
            mem_data_o = sdata_nx;
            state_nx   = ACCESS;
          end
        end
      end
      ACCESS: begin
        stallreq   = 1'b1;
        we_o       = 1'b0;
        mem_re     = req_re;
        mem_we     = req_we;
        mem_sel    = req_sel;
        mem_addr_o = req_addr;
        mem_data_o = req_data;
        if (mem_done_i) state_nx = RESP;
`ifdef MEM_TIMEOUT_EN
        else if (to_hit) state_nx = RESP;
`endif
      end
      RESP: begin
        we_o        = cap_load ? we_i : 1'b0;
        reg_wdata_o = cap_load ? ld_val : reg_wdata_i;
`ifdef MEM_TIMEOUT_EN
        if (timed_out) begin
          we_o        = 1'b0;
          reg_wdata_o = '0;
          err_o       = 1'b1;
        end
`endif
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Outputs are combinational, so reset must gate them directly to be zero immediately.
    if (!rst) begin
      state_nx    = IDLE;
      reg_waddr_o = '0;
      we_o        = 1'b0;
      reg_wdata_o = '0;
      mem_addr_o  = '0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      mem_sel     = 4'b0000;
      mem_data_o  = '0;
      stallreq    = 1'b0;
      misalign_o  = 1'b0;
      err_o       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_re   <= 1'b0;
      req_we   <= 1'b0;
      req_sel  <= 4'b0000;
      req_addr <= '0;
      req_data <= '0;
      cap_data <= '0;
      cap_op   <= 4'd0;
      cap_lo   <= 2'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == ACCESS) begin
        req_re   <= is_load;
        req_we   <= is_store;
        req_sel  <= sel_nx;
        req_addr <= addr_al;
        req_data <= sdata_nx;
        cap_op   <= mem_op_i;
        cap_lo   <= mem_addr_i[1:0];
      end
      if (state == ACCESS && mem_done_i) cap_data <= mem_data_i;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      timed_out <= 1'b0;
    end else if (state == IDLE && state_nx == ACCESS) begin
      cnt       <= '0;
      timed_out <= 1'b0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
      if (to_hit) timed_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_mem_ctrl.sv
// Scoreboard bench for stage_mem_ctrl: stimulus queues expected bus/write-back/misalign/error
// events, a negedge monitor pops and compares whenever the DUT presents one.
module tb_stage_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] reg_wdata_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] rt_data_i = '0;
  logic        mem_busy_i = 1'b0;
  logic        mem_done_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic [4:0]  reg_waddr_o;
  logic        we_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] mem_addr_o;
  logic        mem_re, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_data_o;
  logic        stallreq, misalign_o, err_o;

  stage_mem_ctrl #(.ADDR_W(32), .REG_ADDR_W(5), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .reg_waddr_i(reg_waddr_i), .we_i(we_i), .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_op_i(mem_op_i), .rt_data_i(rt_data_i),
    .mem_busy_i(mem_busy_i), .mem_done_i(mem_done_i), .mem_data_i(mem_data_i),
    .reg_waddr_o(reg_waddr_o), .we_o(we_o), .reg_wdata_o(reg_wdata_o),
    .mem_addr_o(mem_addr_o), .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_data_o(mem_data_o), .stallreq(stallreq), .misalign_o(misalign_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [69:0] bus_q[$];  // {re, we, sel, addr, data}
  logic [36:0] wb_q[$];   // {waddr, wdata}
  logic [3:0]  mis_q[$];  // {re, we, stallreq, we_o}
  logic [32:0] err_q[$];  // {we_o, wdata}
  logic [69:0] bus_e;
  logic [36:0] wb_e;
  logic [3:0]  mis_e;
  logic [32:0] err_e;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT presented an event with nothing expected", nm);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mem_re || mem_we) begin
        if (bus_q.size() == 0) unexpected("bus_req");
        else begin
          bus_e = bus_q.pop_front();
          chk("bus_req", 128'({mem_re, mem_we, mem_sel, mem_addr_o, mem_data_o}), 128'(bus_e));
        end
      end
      if (we_o) begin
        if (wb_q.size() == 0) unexpected("writeback");
        else begin
          wb_e = wb_q.pop_front();
          chk("writeback", 128'({reg_waddr_o, reg_wdata_o}), 128'(wb_e));
        end
      end
      if (misalign_o) begin
        if (mis_q.size() == 0) unexpected("misalign");
        else begin
          mis_e = mis_q.pop_front();
          chk("misalign", 128'({mem_re, mem_we, stallreq, we_o}), 128'(mis_e));
        end
      end
      if (err_o) begin
        if (err_q.size() == 0) unexpected("timeout_err");
        else begin
          err_e = err_q.pop_front();
          chk("timeout_err", 128'({we_o, reg_wdata_o}), 128'(err_e));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_op_i = 4'd0; mem_addr_i = '0; rt_data_i = '0; we_i = 1'b0;
    reg_waddr_i = '0; reg_wdata_i = '0; mem_busy_i = 1'b0;
    mem_done_i = 1'b0; mem_data_i = '0;
  endtask

  // busy_n IDLE cycles with the bus busy (done strobed, must be ignored), then issue,
  // then acc_n ACCESS cycles with done on the last (busy high, must be ignored), then RESP.
  task automatic do_access(input string nm, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rdata,
                           input int busy_n, input int acc_n, input logic ld,
                           input logic [3:0] sel, input logic [31:0] bdata,
                           input logic [31:0] wres);
    mem_op_i = op; mem_addr_i = addr; rt_data_i = rt; we_i = 1'b1;
    reg_waddr_i = 5'd9; reg_wdata_i = 32'h0BAD0BAD;
    for (int i = 0; i < busy_n; i++) begin
      mem_busy_i = 1'b1; mem_done_i = 1'b1; mem_data_i = 32'hBADBADBA;
      @(negedge clk);
      chk({nm, "_busy_stall"}, 128'(stallreq), 128'(1));
      chk({nm, "_busy_noreq"}, 128'({mem_re, mem_we}), 128'(0));
      next_cycle();
    end
    mem_done_i = 1'b0; mem_data_i = '0;
    for (int i = 0; i <= acc_n; i++) begin
      mem_busy_i = (i > 0);
      bus_q.push_back({ld, ~ld, sel, {addr[31:2], 2'b00}, bdata});
      if (i == acc_n) begin
        mem_done_i = 1'b1; mem_data_i = rdata;
      end
      @(negedge clk);
      chk({nm, "_stall"}, 128'(stallreq), 128'(1));
      next_cycle();
    end
    mem_done_i = 1'b0; mem_data_i = '0; mem_busy_i = 1'b0;
    if (ld) wb_q.push_back({5'd9, wres});
    @(negedge clk);
    chk({nm, "_resp_stall"}, 128'(stallreq), 128'(0));
    chk({nm, "_resp_noreq"}, 128'({mem_re, mem_we}), 128'(0));
    if (!ld) chk({nm, "_store_no_wb"}, 128'(we_o), 128'(0));
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    #2;
    @(negedge clk);
    chk("reset_outputs", 128'({reg_waddr_o, we_o, reg_wdata_o, mem_addr_o, mem_re, mem_we,
        mem_sel, mem_data_o, stallreq, misalign_o, err_o}), 128'(0));
    #2 rst = 1'b1;
    next_cycle();

    do_access("lw_100", 4'd3, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF);
    do_access("lb_103", 4'd1, 32'h103, 32'h0, 32'h80123456, 0, 1, 1'b1, 4'b1000, 32'h0, 32'hFFFFFF80);
    do_access("lbu_103", 4'd4, 32'h103, 32'h0, 32'h80123456, 0, 1, 1'b1, 4'b1000, 32'h0, 32'h00000080);
    do_access("lh_100", 4'd2, 32'h100, 32'h0, 32'h12348001, 0, 2, 1'b1, 4'b0011, 32'h0, 32'hFFFF8001);
    do_access("lhu_102", 4'd5, 32'h102, 32'h0, 32'hF00D1234, 0, 1, 1'b1, 4'b1100, 32'h0, 32'h0000F00D);
    do_access("sh_202", 4'd7, 32'h202, 32'h1234ABCD, 32'h0, 0, 1, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
    do_access("sb_201", 4'd6, 32'h201, 32'h000000EF, 32'h0, 0, 1, 1'b0, 4'b0010, 32'hEFEFEFEF, 32'h0);
    do_access("sw_busy3", 4'd8, 32'h300, 32'hCAFEF00D, 32'h0, 3, 1, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0);
    do_access("lw_slow", 4'd3, 32'h404, 32'h0, 32'h01020304, 0, 6, 1'b1, 4'b1111, 32'h0, 32'h01020304);

    // misaligned word and halfword: flag only, no request, no stall, no write-back
    mem_op_i = 4'd3; mem_addr_i = 32'h101; we_i = 1'b1; reg_waddr_i = 5'd4;
    mis_q.push_back(4'b0000);
    @(negedge clk);
    chk("mis_lw_flag", 128'(misalign_o), 128'(1));
    next_cycle();
    mem_op_i = 4'd2; mem_addr_i = 32'h103;
    mis_q.push_back(4'b0000);
    @(negedge clk);
    chk("mis_lh_flag", 128'(misalign_o), 128'(1));
    next_cycle();

    // non-memory op passes straight through
    mem_op_i = 4'd0; mem_addr_i = '0; reg_waddr_i = 5'd3; reg_wdata_i = 32'h55; we_i = 1'b1;
    wb_q.push_back({5'd3, 32'h55});
    @(negedge clk);
    chk("passthru_stall", 128'({stallreq, misalign_o}), 128'(0));
    next_cycle();
    mem_op_i = 4'd12; reg_waddr_i = 5'd17; reg_wdata_i = 32'hA5A5_0001;
    wb_q.push_back({5'd17, 32'hA5A50001});
    @(negedge clk);
    chk("op12_noreq", 128'({mem_re, mem_we, stallreq}), 128'(0));
    next_cycle();
    idle_inputs();
    next_cycle();

    // reset asserted mid-ACCESS: outputs drop immediately, no write-back afterwards
    mem_op_i = 4'd3; mem_addr_i = 32'h400; we_i = 1'b1; reg_waddr_i = 5'd9;
    reg_wdata_i = 32'h77;
    bus_q.push_back({1'b1, 1'b0, 4'b1111, 32'h400, 32'h0});
    @(negedge clk);
    next_cycle();
    bus_q.push_back({1'b1, 1'b0, 4'b1111, 32'h400, 32'h0});
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_access", 128'({reg_waddr_o, we_o, reg_wdata_o, mem_addr_o, mem_re, mem_we,
        mem_sel, mem_data_o, stallreq, misalign_o, err_o}), 128'(0));
    idle_inputs();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("after_rst_idle", 128'({we_o, mem_re, mem_we, stallreq}), 128'(0));
    next_cycle();

`ifdef MEM_TIMEOUT_EN
    mem_op_i = 4'd3; mem_addr_i = 32'h500; we_i = 1'b1; reg_waddr_i = 5'd9;
    reg_wdata_i = 32'h1234;
    for (int i = 0; i <= 4; i++) begin
      bus_q.push_back({1'b1, 1'b0, 4'b1111, 32'h500, 32'h0});
      @(negedge clk);
      chk("to_stall", 128'(stallreq), 128'(1));
      next_cycle();
    end
    err_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    chk("to_resp", 128'({err_o, stallreq, mem_re}), 128'(3'b100));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("to_back_idle", 128'({err_o, stallreq}), 128'(0));
    next_cycle();
`else
    do_access("lw_no_timeout", 4'd3, 32'h500, 32'h0, 32'h00C0FFEE, 0, 8, 1'b1, 4'b1111, 32'h0, 32'h00C0FFEE);
`endif

    repeat (2) next_cycle();
    chk("bus_q_drained", 128'(bus_q.size()), 128'(0));
    chk("wb_q_drained", 128'(wb_q.size()), 128'(0));
    chk("mis_q_drained", 128'(mis_q.size()), 128'(0));
    chk("err_q_drained", 128'(err_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
